// File: rtl/lsu.sv
// RV32I load/store unit: one memory transaction per instruction over a valid/ready bus,
// with lane formatting, load extension, a response timeout and ALU pass-through.
module lsu #(
  parameter int RESP_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_OUT} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_load;
  logic [2:0]       r_func3;
  logic [1:0]       r_off;
  logic [31:0]      r_req_addr, r_wdata, r_out_data;
  logic [3:0]       r_wmask;
  logic             r_wen, r_err;

  logic        w_accept, w_is_mem, w_legal, w_misal, w_timeout;
  logic [31:0] w_wdata, w_load_data;
  logic [3:0]  w_wmask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept  = in_valid && in_ready;
  assign w_is_mem  = is_load || is_store;
  assign w_misal   = ((func3[1:0] == 2'd1) && addr[0]) ||
                     ((func3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
  assign w_timeout = (r_cnt == CNT_W'(RESP_TIMEOUT - 1));

  always_comb begin
    w_legal = 1'b0;
    if (is_load)
      w_legal = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                (func3 == 3'd4) || (func3 == 3'd5);
    else if (is_store)
      w_legal = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2);
  end

  always_comb begin
    w_wdata = store_data;
    w_wmask = 4'b1111;
    case (func3[1:0])
      2'd0: begin
        w_wdata = {4{store_data[7:0]}};
        w_wmask = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{store_data[15:0]}};
        w_wmask = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_byte = mem_resp_rdata[{r_off, 3'b000} +: 8];
  assign w_half = mem_resp_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_func3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = mem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (!w_is_mem || !w_legal || w_misal) ? S_OUT : S_REQ;
      S_REQ:  if (mem_req_ready) w_next = S_RESP;
      S_RESP: if (mem_resp_valid || w_timeout) w_next = S_OUT;
      S_OUT:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE) && !rst;
    mem_req_valid = (r_state == S_REQ);
    out_valid     = (r_state == S_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_is_load  <= 1'b0;
      r_func3    <= 3'd0;
      r_off      <= 2'd0;
      r_req_addr <= 32'd0;
      r_wdata    <= 32'd0;
      r_wmask    <= 4'd0;
      r_wen      <= 1'b0;
      r_out_data <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_load  <= is_load;
        r_func3    <= func3;
        r_off      <= addr[1:0];
        r_req_addr <= {addr[31:2], 2'b00};
        r_wen      <= is_store;
        r_wdata    <= is_store ? w_wdata : 32'd0;
        r_wmask    <= is_store ? w_wmask : 4'd0;
        if (!w_is_mem) begin
          r_out_data <= addr;
          r_err      <= 1'b0;
        end else if (!w_legal || w_misal) begin
          r_out_data <= 32'd0;
          r_err      <= 1'b1;
        end
      end
      if (r_state == S_REQ) r_cnt <= '0;
      else if (r_state == S_RESP) r_cnt <= r_cnt + 1'b1;
      // a response arriving on the timeout cycle still counts as a completion
      if (r_state == S_RESP) begin
        if (mem_resp_valid) begin
          r_out_data <= r_is_load ? w_load_data : 32'd0;
          r_err      <= 1'b0;
        end else if (w_timeout) begin
          r_out_data <= 32'd0;
          r_err      <= 1'b1;
        end
      end
    end
  end

  assign mem_req_addr  = r_req_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign out_data      = r_out_data;
  assign err           = r_err;

endmodule

// File: doc/lsu.md
Name:
lsu

Overview:
- Load/store unit on the consumer side of the execute stage. It accepts an effective address and store data from EXU, plus func3 from the decoder.
- Runs one memory transaction on a valid/ready request bus and waits for the response.
- Returns writeback data that is sign- or zero-extended per RV32I, along with an error flag.
- Non-memory instructions pass through: the ALU result is forwarded unchanged.

Parameters:
- RESP_TIMEOUT, 255: maximum number of cycles spent in RESP before the transaction aborts with err.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > RESP_TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  EXU presents an instruction
- in_ready  output  1  LSU can accept an instruction
- is_load  input  1  instruction is a load
- is_store  input  1  instruction is a store; is_load and is_store are never both 1
- func3  input  3  RV32I width/sign code
- addr  input  32  effective address (EXU result) or ALU result for non-memory ops
- store_data  input  32  rs2 value
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts the request
- mem_req_addr  output  32  {addr[31:2],2'b00}
- mem_req_wen  output  1  1 = write
- mem_req_wdata  output  32  lane-replicated store data
- mem_req_wmask  output  4  byte enables; 0000 for reads
- mem_resp_valid  input  1  read data or write acknowledge, single-cycle pulse
- mem_resp_rdata  input  32  read data word
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts the result
- out_data  output  32  writeback value
- err  output  1  misaligned, illegal func3, or timeout; qualified by out_valid

Behaviour:
- Reset:
  - state = IDLE, counter = 0.
  - mem_req_valid, mem_req_wen, out_valid and err are 0.
  - mem_req_addr, mem_req_wdata, mem_req_wmask and out_data are 0.
  - in_ready = 0 while rst is asserted.
- FSM states: IDLE, REQ, RESP, OUT.
- in_ready = (state==IDLE) && !rst. All fields are captured in registers on in_valid && in_ready.
- Transitions from IDLE on accept:
  - Neither is_load nor is_store: go to OUT with out_data = addr and err = 0. One-cycle latency.
  - Illegal func3: go to OUT with err = 1, out_data = 0, and no bus request. Legal load func3 values are 0, 1, 2, 4, 5; legal store func3 values are 0, 1, 2.
  - Misaligned access: go to OUT with err = 1, out_data = 0, and no bus request. Halfword is misaligned when addr[0] = 1; word is misaligned when addr[1:0] != 0.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid = 1; address, wen, wdata and wmask are held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to RESP and clear the counter.
  - REQ has no timeout.
- Store lane formatting:
  - SB: wdata = {4{sd[7:0]}}, wmask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, wmask = 4'b0011 << addr[1:0].
  - SW: wdata = sd, wmask = 4'b1111.
- RESP:
  - The counter increments each cycle.
  - On mem_resp_valid, go to OUT with err = 0. A load's out_data is the extracted value; a store's out_data is 0.
  - If the counter reaches RESP_TIMEOUT with no response, go to OUT with err = 1 and out_data = 0.
  - A response and the timeout in the same cycle: the response wins.
- Load extraction: take byte = rdata[8*addr[1:0] +: 8] and half = rdata[16*addr[1] +: 16], then:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - LW: the full word.
- mem_resp_valid is ignored in every state except RESP. This includes the request-handshake cycle and any late response arriving after a timeout.
- OUT:
  - out_valid = 1; out_data and err are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - A new instruction can be accepted the cycle after the OUT handshake. Back-to-back throughput for non-memory ops is one instruction per 2 cycles.
- Reset mid-transaction: the current transaction is abandoned immediately and outputs return to their reset values. A response still arriving from memory lands in IDLE and is ignored.
- Minimum load latency: accept → REQ (1 cycle) → RESP (at least 1 cycle) → OUT, which gives out_valid at the earliest 3 cycles after accept when memory responds in zero wait states.

Test Plan:
- Non-memory pass-through: in_valid with is_load = is_store = 0, addr = 32'h1234_5678 → out_valid next cycle with out_data = 32'h1234_5678, err = 0, and no mem_req_valid.
- Sign/zero extension: LB at addr 0x8000_0003 with rdata = 32'h80FF_0011 → mem_req_addr = 0x8000_0000, out_data = 32'hFFFF_FF80. The same access as LBU → 32'h0000_0080. LH at 0x8000_0002 → 32'hFFFF_80FF.
- Store formatting: SH at 0x8000_0002 with store_data = 32'hAAAA_BEEF → wdata = 32'hBEEF_BEEF, wmask = 4'b1100, wen = 1. Hold mem_req_ready low for 3 cycles → request fields stable throughout. After ack → out_data = 0, err = 0.
- Misaligned and illegal: LW at 0x8000_0001 → err = 1, no mem_req_valid. A load with func3 = 3 → err = 1, no mem_req_valid.
- Timeout: RESP_TIMEOUT = 4 with no response → err = 1 after 4 RESP cycles. A response pulse 2 cycles later → ignored; the next instruction completes normally.
- Backpressure and reset: hold out_ready low for 5 cycles → out_data and err stable, in_ready = 0. Assert rst during RESP → all outputs 0 immediately; a late mem_resp_valid produces no out_valid.
